// File: rtl/program_memory.sv
// program_memory: 16-bit word instruction store with a byte-serial loader.
// The processor fetches combinationally via pc/instruction. A load session
// writes ld_count words, low byte first, while cpu_rst holds the processor.
// Optional feature: define PROGMEM_CHECKSUM_EN to add a 16-bit running sum
// of all words written since the last accepted ld_start.
`ifndef BITNESS
`define BITNESS 16
`endif

module program_memory #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [15:0] FILL   = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [`BITNESS-1:0] pc,
  output logic [15:0]         instruction,
  input  logic                ld_start,
  input  logic [ADDR_W:0]     ld_count,
  input  logic [7:0]          ld_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  output logic                cpu_rst,
  output logic                busy,
  output logic                err
`ifdef PROGMEM_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);

  localparam int unsigned     Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StRelease
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W:0]     r_remaining;
  logic [7:0]          r_lo;
  logic                r_err;
  logic                r_ld_ready;
  logic                r_busy;
  logic                r_cpu_rst;
  logic [15:0]         r_mem [Depth];

  logic                w_count_ok;
  logic                w_start_ok;
  logic                w_accept;
  logic                w_wr_en;
  logic [15:0]         w_wr_word;
  logic                w_in_range;

  assign w_count_ok = (ld_count != '0) && (ld_count <= MaxCount);
  assign w_start_ok = ld_start && w_count_ok && (r_state == StIdle);
  assign w_accept   = ld_valid && r_ld_ready;
  // rst wins over a byte arriving in HI so a mid-session reset never writes
  assign w_wr_en    = !rst && (r_state == StHi) && w_accept;
  assign w_wr_word  = {ld_data, r_lo};

  // Any set bit above the address field means the fetch is out of range
  assign w_in_range  = ((pc >> ADDR_W) == '0);
  assign instruction = w_in_range ? r_mem[pc[ADDR_W-1:0]] : FILL;

  assign ld_ready = r_ld_ready;
  assign cpu_rst  = r_cpu_rst;
  assign busy     = r_busy;
  assign err      = r_err;

  // Memory write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_waddr] <= w_wr_word;
    end
  end

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_waddr     <= '0;
      r_remaining <= '0;
      r_lo        <= '0;
      r_err       <= 1'b0;
      r_ld_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_cpu_rst   <= 1'b1;
    end else begin
      // Rejected starts: bad count in IDLE, or any start during a session
      if (ld_start && ((r_state != StIdle) || !w_count_ok)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          r_cpu_rst <= 1'b0;
          if (w_start_ok) begin
            r_remaining <= ld_count;
            r_waddr     <= '0;
            r_cpu_rst   <= 1'b1;
            r_ld_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StLo;
          end
        end
        StLo: begin
          if (w_accept) begin
            r_lo    <= ld_data;
            r_state <= StHi;
          end
        end
        StHi: begin
          if (w_accept) begin
            r_waddr     <= r_waddr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CountOne) begin
              r_ld_ready <= 1'b0;
              r_state    <= StRelease;
            end else begin
              r_state <= StLo;
            end
          end
        end
        StRelease: begin
          r_cpu_rst <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= StIdle;
        end
        default: begin
          r_ld_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

`ifdef PROGMEM_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running mod-2^16 sum of words written in the current session
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_wr_en) begin
      r_checksum <= r_checksum + w_wr_word;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_program_memory.sv
// Directed self-checking bench for program_memory (ADDR_W=8, FILL=DEAD).
`ifndef BITNESS
`define BITNESS 16
`endif

module tb_program_memory;

  localparam int unsigned AW    = 8;
  localparam logic [15:0] FillW = 16'hDEAD;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [`BITNESS-1:0] pc = '0;
  logic [15:0]         instruction;
  logic                ld_start = 1'b0;
  logic [AW:0]         ld_count = '0;
  logic [7:0]          ld_data = '0;
  logic                ld_valid = 1'b0;
  logic                ld_ready;
  logic                cpu_rst;
  logic                busy;
  logic                err;
`ifdef PROGMEM_CHECKSUM_EN
  logic [15:0]         checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  program_memory #(
    .ADDR_W(AW),
    .FILL  (FillW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction),
    .ld_start   (ld_start),
    .ld_count   (ld_count),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .err        (err)
`ifdef PROGMEM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input int unsigned a);
    pc = `BITNESS'(a);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
  endtask

  task automatic start(input int unsigned cnt);
    ld_start = 1'b1;
    ld_count = (AW + 1)'(cnt);
    tick();
    ld_start = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst got %b exp 1", cpu_rst); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_tests++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL rst_release got %b exp 0", cpu_rst); end
  endtask

  task automatic test_load();
    // EE offered alongside ld_start must be ignored
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    start(2);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b exp 1", busy); end
    n_tests++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b exp 1", ld_ready); end
    n_tests++;
    if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL load_cpu_rst got %b exp 1", cpu_rst); end
    put_byte(8'h34);
    put_byte(8'h12);
    set_pc(0);
    n_tests++;
    if (instruction !== 16'h1234) begin
      n_fail++; $display("FAIL load_word0 got %h exp 1234", instruction);
    end
    put_byte(8'hCD);
    put_byte(8'hAB);
    ld_valid = 1'b0;
    n_tests++;
    if (cpu_rst !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_release got cpu_rst=%b busy=%b rdy=%b exp 1 1 0", cpu_rst, busy, ld_ready);
    end
    tick();
    n_tests++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL load_idle got cpu_rst=%b busy=%b exp 0 0", cpu_rst, busy);
    end
    set_pc(1);
    n_tests++;
    if (instruction !== 16'hABCD) begin
      n_fail++; $display("FAIL load_word1 got %h exp abcd", instruction);
    end
  endtask

  task automatic test_backpressure();
    ld_valid = 1'b0;
    start(1);
    tick();
    n_tests++;
    if (ld_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_lo_hold got rdy=%b busy=%b exp 1 1", ld_ready, busy);
    end
    put_byte(8'h21);
    ld_valid = 1'b0;
    ld_data  = 8'h99;
    tick();
    set_pc(0);
    n_tests++;
    if (ld_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_hi_hold got rdy=%b busy=%b exp 1 1", ld_ready, busy);
    end
    n_tests++;
    if (instruction !== 16'h1234) begin
      n_fail++; $display("FAIL bp_no_write got %h exp 1234", instruction);
    end
    put_byte(8'h43);
    ld_valid = 1'b0;
    n_tests++;
    if (ld_ready !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got rdy=%b cpu_rst=%b exp 0 1", ld_ready, cpu_rst);
    end
    n_tests++;
    if (instruction !== 16'h4321) begin
      n_fail++; $display("FAIL bp_word0 got %h exp 4321", instruction);
    end
    set_pc(1);
    n_tests++;
    if (instruction !== 16'hABCD) begin
      n_fail++; $display("FAIL bp_word1 got %h exp abcd", instruction);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b exp 0", busy); end
  endtask

  task automatic test_bad_start();
    do_reset();
    start(0);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL bad_zero got err=%b busy=%b rdy=%b exp 1 0 0", err, busy, ld_ready);
    end
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL bad_err_clear got %b exp 0", err); end
    start(257);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL bad_big got err=%b busy=%b rdy=%b exp 1 0 0", err, busy, ld_ready);
    end
    do_reset();
    start(256);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_max_ok got err=%b busy=%b exp 0 1", err, busy);
    end
    do_reset();
    start(1);
    ld_start = 1'b1;
    ld_count = (AW + 1)'(2);
    tick();
    ld_start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL bad_mid got err=%b busy=%b rdy=%b exp 1 1 1", err, busy, ld_ready);
    end
    put_byte(8'h78);
    put_byte(8'h56);
    ld_valid = 1'b0;
    n_tests++;
    if (ld_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_mid_release got rdy=%b busy=%b exp 0 1", ld_ready, busy);
    end
    tick();
    set_pc(0);
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL bad_mid_done got busy=%b err=%b exp 0 1", busy, err);
    end
    n_tests++;
    if (instruction !== 16'h5678) begin
      n_fail++; $display("FAIL bad_mid_word got %h exp 5678", instruction);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(4);
    put_byte(8'h11);
    put_byte(8'h22);
    put_byte(8'h33);
    rst      = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'h44;
    tick();
    n_tests++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got cpu_rst=%b busy=%b rdy=%b exp 1 0 0", cpu_rst, busy, ld_ready);
    end
    rst      = 1'b0;
    ld_valid = 1'b0;
    tick();
    n_tests++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after got cpu_rst=%b busy=%b exp 0 0", cpu_rst, busy);
    end
    set_pc(0);
    n_tests++;
    if (instruction !== 16'h2211) begin
      n_fail++; $display("FAIL mid_word0 got %h exp 2211", instruction);
    end
    set_pc(1);
    n_tests++;
    if (instruction !== 16'hABCD) begin
      n_fail++; $display("FAIL mid_word1 got %h exp abcd", instruction);
    end
  endtask

  task automatic test_range_order();
    set_pc(256);
    n_tests++;
    if (instruction !== FillW) begin
      n_fail++; $display("FAIL range_256 got %h exp dead", instruction);
    end
    set_pc(16'h0105);
    n_tests++;
    if (instruction !== FillW) begin
      n_fail++; $display("FAIL range_105 got %h exp dead", instruction);
    end
    start(6);
    for (int k = 0; k < 6; k++) begin
      put_byte(8'(k));
      put_byte(8'h10);
    end
    ld_valid = 1'b0;
    tick();
    start(6);
    for (int k = 0; k < 5; k++) begin
      put_byte(8'(k));
      put_byte(8'h20);
    end
    put_byte(8'h05);
    ld_valid = 1'b1;
    ld_data  = 8'h20;
    set_pc(5);
    n_tests++;
    if (instruction !== 16'h1005) begin
      n_fail++; $display("FAIL order_old got %h exp 1005", instruction);
    end
    tick();
    ld_valid = 1'b0;
    n_tests++;
    if (instruction !== 16'h2005) begin
      n_fail++; $display("FAIL order_new got %h exp 2005", instruction);
    end
    set_pc(4);
    n_tests++;
    if (instruction !== 16'h2004) begin
      n_fail++; $display("FAIL order_word4 got %h exp 2004", instruction);
    end
    tick();
  endtask

`ifdef PROGMEM_CHECKSUM_EN
  task automatic test_checksum();
    start(2);
    n_tests++;
    if (checksum !== 16'h0000) begin
      n_fail++; $display("FAIL csum_clear got %h exp 0000", checksum);
    end
    put_byte(8'hFF);
    put_byte(8'hFF);
    put_byte(8'h02);
    put_byte(8'h00);
    ld_valid = 1'b0;
    n_tests++;
    if (checksum !== 16'h0001) begin
      n_fail++; $display("FAIL csum_sum got %h exp 0001", checksum);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_backpressure();
    test_bad_start();
    test_reset_mid();
    test_range_order();
`ifdef PROGMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
